mips_boot_loader: RTL

Boot-time program loader upstream of `mips_processor`. It receives a byte stream over a valid/ready interface, assembles big-endian 32-bit instruction words and writes them into the instruction memory, then releases the processor's reset once an 8-bit checksum is validated. The processor stays in reset (`cpu_rst_n` = 0) until a load completes successfully.

---
 rtl/mips_boot_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/mips_boot_loader.sv
// Boot loader: receives a framed byte stream, writes big-endian words into
// instruction memory, and releases the processor reset after a valid checksum.
module mips_boot_loader #(
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [PC_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    PAYLOAD,
    CHECK,
    RUN,
    ERROR
  } state_t;

  localparam logic [15:0] MAX_WORDS = 16'(MEM_SIZE);

  state_t                state, state_next;
  logic [7:0]            n_hi;
  logic [15:0]           word_cnt;
  logic [1:0]            byte_cnt;
  logic [PC_WIDTH-1:0]   word_idx;
  logic [23:0]           word_sr;
  logic [7:0]            csum;
  logic                  accept;
  logic [15:0]           n_full;
  logic                  last_word;

  // Gated by rst_n directly so no byte is taken during the reset cycle.
  assign rx_ready = rst_n && ((state == HDR_HI) || (state == HDR_LO) ||
                              (state == PAYLOAD) || (state == CHECK));
  assign accept    = rx_valid && rx_ready;
  assign n_full    = {n_hi, rx_data};
  assign last_word = (word_idx == PC_WIDTH'(word_cnt - 16'd1));

  assign cpu_rst_n  = (state == RUN);
  assign load_done  = (state == RUN);
  assign load_error = (state == ERROR);

  always_comb begin
    state_next = state;
    case (state)
      HDR_HI:  if (accept) state_next = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (n_full > MAX_WORDS)    state_next = ERROR;
          else if (n_full == 16'd0)  state_next = CHECK;
          else                       state_next = PAYLOAD;
        end
      end
      PAYLOAD: if (accept && (byte_cnt == 2'd3) && last_word) state_next = CHECK;
      CHECK:   if (accept) state_next = (rx_data == csum) ? RUN : ERROR;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HDR_HI;
      n_hi      <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      word_idx  <= '0;
      word_sr   <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_next;
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          HDR_HI: n_hi <= rx_data;
          HDR_LO: begin
            word_cnt <= n_full;
            csum     <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
          end
          PAYLOAD: begin
            csum     <= csum + rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            word_sr  <= {word_sr[15:0], rx_data};
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= {word_idx[PC_WIDTH-3:0], 2'b00};
              mem_wdata <= {word_sr, rx_data};
              word_idx  <= word_idx + PC_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
